// File: rtl/gpr_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_ctrl
// Description : Writeback controller that owns the single register-file
//               write port. Pipeline results are written one cycle after
//               they are presented. Long-latency results are buffered in a
//               small FIFO and drained whenever the pipeline leaves the
//               write port idle. A busy mask tracks destination registers
//               that still wait on a long-latency result.
//
// Ports       : clk, rst               clock, synchronous active-high reset
//               pipe_we/addr/data      main-pipeline writeback (always taken)
//               issue_valid/addr       long-latency issue (sets a busy bit)
//               ll_valid/ready/addr/data
//                                      long-latency result handshake
//               gpr_we/addr/data       registered register-file write port
//               busy_mask              registered outstanding-result mask
//
// Revision    : 1.0  initial release
// ============================================================================
module gpr_wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_addr,
    input  logic [31:0] ll_data,
    output logic        gpr_we,
    output logic [4:0]  gpr_addr,
    output logic [31:0] gpr_data,
    output logic [31:0] busy_mask
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

    // FIFO storage and bookkeeping
    logic [4:0]       r_fifo_addr [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_pipe_win;
    logic [4:0]       w_head_addr;
    logic [31:0]      w_head_data;
    logic [31:0]      w_set;
    logic [31:0]      w_clr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    // Readiness depends on occupancy only, so a same-cycle pop never
    // opens a slot for a same-cycle push when the FIFO is full.
    assign ll_ready = !rst && (r_count < c_depth);

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    always_comb begin
        w_push     = ll_valid && ll_ready;
        // A pipeline write to r0 is a no-op and must not steal the port.
        w_pipe_win = pipe_we && (pipe_addr != 5'd0);
        w_pop      = !w_pipe_win && (r_count != '0);

        // Explicit wrap keeps non-power-of-two depths correct.
        w_wr_ptr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_nxt = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;

        w_set = 32'b0;
        if (issue_valid && (issue_addr != 5'd0)) begin
            w_set[issue_addr] = 1'b1;
        end

        w_clr = 32'b0;
        if (w_pop && (w_head_addr != 5'd0)) begin
            w_clr[w_head_addr] = 1'b1;
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= ll_addr;
            r_fifo_data[r_wr_ptr] <= ll_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            gpr_we    <= 1'b0;
            gpr_addr  <= 5'd0;
            gpr_data  <= 32'd0;
            busy_mask <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A popped head addressed to r0 is discarded without a write.
            gpr_we <= w_pipe_win || (w_pop && (w_head_addr != 5'd0));
            if (w_pipe_win) begin
                gpr_addr <= pipe_addr;
                gpr_data <= pipe_data;
            end else if (w_pop) begin
                gpr_addr <= w_head_addr;
                gpr_data <= w_head_data;
            end

            // Set after clear: a re-issue on the popping edge keeps the bit.
            busy_mask <= (busy_mask & ~w_clr) | w_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb_ctrl
// Description : Self-checking bench for gpr_wb_ctrl. Expected register-file
//               writes are queued when stimulus is applied; a monitor pops
//               and compares on every gpr_we pulse. Cycle-exact timing of
//               handshake, write pulses and busy bits is checked inline.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gpr_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    logic        gpr_we;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_data;
    logic [31:0] busy_mask;

    int n_vec;
    int n_err;

    logic [36:0] exp_q [$];

    gpr_wb_ctrl #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_addr   (pipe_addr),
        .pipe_data   (pipe_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .ll_valid    (ll_valid),
        .ll_ready    (ll_ready),
        .ll_addr     (ll_addr),
        .ll_data     (ll_data),
        .gpr_we      (gpr_we),
        .gpr_addr    (gpr_addr),
        .gpr_data    (gpr_data),
        .busy_mask   (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expectation.
    always @(posedge clk) begin
        #2;
        if (gpr_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         gpr_addr, gpr_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {27'd0, gpr_addr}, {27'd0, e[36:32]});
                chk("wr_data", gpr_data, e[31:0]);
            end
        end
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        pipe_we     = 1'b0;
        pipe_addr   = 5'd0;
        pipe_data   = 32'd0;
        issue_valid = 1'b0;
        issue_addr  = 5'd0;
        ll_valid    = 1'b1;
        ll_addr     = 5'd1;
        ll_data     = 32'hFEEDF00D;

        // ---- reset held two cycles with a result offered ----
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gpr_we", {31'd0, gpr_we}, 32'd0);
            chk("rst_gpr_addr", {27'd0, gpr_addr}, 32'd0);
            chk("rst_gpr_data", gpr_data, 32'd0);
            chk("rst_busy", busy_mask, 32'd0);
            chk("rst_ll_ready", {31'd0, ll_ready}, 32'd0);
        end
        rst      = 1'b0;
        ll_valid = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, ll_ready}, 32'd1);
        tick();
        tick();
        chk("post_rst_no_write", {31'd0, gpr_we}, 32'd0);

        // ---- pipeline path ----
        pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        pipe_we = 1'b0;
        chk("pipe_we", {31'd0, gpr_we}, 32'd1);
        chk("pipe_addr", {27'd0, gpr_addr}, 32'd5);
        chk("pipe_data", gpr_data, 32'hDEADBEEF);
        chk("pipe_busy", busy_mask, 32'd0);
        tick();
        chk("pipe_pulse_end", {31'd0, gpr_we}, 32'd0);

        // ---- issue / drain ----
        issue_valid = 1'b1; issue_addr = 5'd8;
        tick();
        issue_valid = 1'b0;
        chk("issue_busy8", busy_mask, 32'h0000_0100);
        ll_valid = 1'b1; ll_addr = 5'd8; ll_data = 32'h12345678;
        #1;
        chk("drain_ready", {31'd0, ll_ready}, 32'd1);
        expect_wr(5'd8, 32'h12345678);
        tick();
        ll_valid = 1'b0;
        chk("drain_not_yet", {31'd0, gpr_we}, 32'd0);
        chk("drain_busy_held", busy_mask, 32'h0000_0100);
        tick();
        chk("drain_we", {31'd0, gpr_we}, 32'd1);
        chk("drain_addr", {27'd0, gpr_addr}, 32'd8);
        chk("drain_busy_clr", busy_mask, 32'd0);
        tick();
        chk("drain_pulse_end", {31'd0, gpr_we}, 32'd0);

        // ---- contention: pipeline every cycle, two results buffered ----
        issue_valid = 1'b1; issue_addr = 5'd3;
        tick();
        issue_addr = 5'd4;
        tick();
        issue_valid = 1'b0;
        chk("cont_busy34", busy_mask, 32'h0000_0018);
        pipe_we = 1'b1; pipe_addr = 5'd10; pipe_data = 32'hA0A0_0010;
        expect_wr(5'd10, 32'hA0A0_0010);
        ll_valid = 1'b1; ll_addr = 5'd3; ll_data = 32'h3333_3333;
        tick();
        chk("cont_p0", {26'd0, gpr_we, gpr_addr}, {26'd0, 1'b1, 5'd10});
        pipe_addr = 5'd11; pipe_data = 32'hA0A0_0011;
        expect_wr(5'd11, 32'hA0A0_0011);
        ll_addr = 5'd4; ll_data = 32'h4444_4444;
        tick();
        chk("cont_p1", {26'd0, gpr_we, gpr_addr}, {26'd0, 1'b1, 5'd11});
        chk("cont_full", {31'd0, ll_ready}, 32'd0);
        pipe_addr = 5'd12; pipe_data = 32'hA0A0_0012;
        expect_wr(5'd12, 32'hA0A0_0012);
        ll_addr = 5'd5; ll_data = 32'h5555_5555;
        tick();
        chk("cont_p2", {26'd0, gpr_we, gpr_addr}, {26'd0, 1'b1, 5'd12});
        chk("cont_still_full", {31'd0, ll_ready}, 32'd0);
        pipe_addr = 5'd13; pipe_data = 32'hA0A0_0013;
        expect_wr(5'd13, 32'hA0A0_0013);
        tick();
        chk("cont_p3", {26'd0, gpr_we, gpr_addr}, {26'd0, 1'b1, 5'd13});
        chk("cont_busy_held", busy_mask, 32'h0000_0018);
        pipe_we  = 1'b0;
        ll_valid = 1'b0;
        expect_wr(5'd3, 32'h3333_3333);
        expect_wr(5'd4, 32'h4444_4444);
        tick();
        chk("cont_r3", {26'd0, gpr_we, gpr_addr}, {26'd0, 1'b1, 5'd3});
        chk("cont_busy_r3_clr", busy_mask, 32'h0000_0010);
        tick();
        chk("cont_r4", {26'd0, gpr_we, gpr_addr}, {26'd0, 1'b1, 5'd4});
        chk("cont_busy_r4_clr", busy_mask, 32'd0);
        tick();
        chk("cont_drained", {31'd0, gpr_we}, 32'd0);

        // ---- r0: pipeline write to r0 does not block the FIFO head ----
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h0000_0020;
        expect_wr(5'd20, 32'h0000_0020);
        ll_valid = 1'b1; ll_addr = 5'd7; ll_data = 32'h7777_7777;
        tick();
        ll_valid = 1'b0;
        pipe_addr = 5'd0; pipe_data = 32'h0000_0BAD;
        expect_wr(5'd7, 32'h7777_7777);
        tick();
        pipe_we = 1'b0;
        chk("r0_pipe_r7", {26'd0, gpr_we, gpr_addr}, {26'd0, 1'b1, 5'd7});
        chk("r0_pipe_busy7", busy_mask, 32'd0);

        // ---- r0: long-latency result to r0 is popped silently ----
        ll_valid = 1'b1; ll_addr = 5'd0; ll_data = 32'h0000_0ABC;
        tick();
        ll_valid = 1'b0;
        tick();
        chk("r0_ll_no_we", {31'd0, gpr_we}, 32'd0);
        tick();
        chk("r0_ll_no_we2", {31'd0, gpr_we}, 32'd0);

        // ---- same-edge set and clear on r9 ----
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        issue_valid = 1'b0;
        ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'h9999_9999;
        expect_wr(5'd9, 32'h9999_9999);
        tick();
        ll_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        issue_valid = 1'b0;
        chk("same_edge_r9", {26'd0, gpr_we, gpr_addr}, {26'd0, 1'b1, 5'd9});
        chk("same_edge_busy9", busy_mask, 32'h0000_0200);
        tick();
        chk("same_edge_busy9_hold", busy_mask, 32'h0000_0200);

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Writeback controller that owns the single write port of the register file. It merges same-cycle results from the main pipeline with out-of-order results from the long-latency unit (mult/div, loads), buffering the latter in a small FIFO. It also tracks registers with a long-latency result still outstanding, as a busy mask that decode uses for stalling. It sits between the EX/MEM pipeline and the register file's `write_enable` / `addr_write_in` / `data_write` inputs.

## Interface
- `DEPTH`, default 2: long-latency result FIFO depth, at least 1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pipe_we`  in  1  main-pipeline writeback request this cycle; always accepted.
- `pipe_addr`  in  5  destination register of the pipeline result.
- `pipe_data`  in  32  pipeline result.
- `issue_valid`  in  1  a long-latency op is issued this cycle.
- `issue_addr`  in  5  destination register of the issued op.
- `ll_valid`  in  1  long-latency result offered.
- `ll_ready`  out  1  FIFO can accept a result.
- `ll_addr`  in  5  destination register of the offered result.
- `ll_data`  in  32  offered result.
- `gpr_we`  out  1  register-file write enable (registered).
- `gpr_addr`  out  5  register-file write address (registered).
- `gpr_data`  out  32  register-file write data (registered).
- `busy_mask`  out  32  bit n set while register n awaits a long-latency result (registered).

## Operation
- **Handshake:** a long-latency result transfers on an edge where `ll_valid && ll_ready`. The result is pushed at FIFO tail.
  - `ll_ready = !rst && (count < DEPTH)`, a function of occupancy only.
  - A pop in the same cycle does not raise `ll_ready`.
- **Write-port arbitration** is evaluated each cycle. Only one source can win.
  - Pipeline wins if `pipe_we && pipe_addr != 0`.
  - Otherwise, if the FIFO is non-empty, the head is popped.
  - Only one FIFO entry can be popped per cycle.
- **Register 0:**
  - A pipeline write to r0 is ignored and does not block the FIFO.
  - A FIFO head with addr 0 is popped without a write (`gpr_we` = 0 that cycle).
- **Busy mask:**
  - `issue_valid && issue_addr != 0` sets bit `issue_addr`.
  - Popping a head with addr n (n ≠ 0) clears bit n.
  - If set and clear hit the same bit on the same edge, set wins.
  - A pipeline write never alters `busy_mask`.
- **Protocol obligation (upstream):** decode must not issue to a register whose busy bit is set. The block does not detect this violation.
- **Pushing and popping:** simultaneous push and pop are permitted when count < DEPTH; count is then unchanged.
- **FIFO wrap-around:** read and write pointers wrap modulo `DEPTH`. With DEPTH not a power of two, the pointers wrap explicitly at DEPTH-1.
- **Starvation:** FIFO drain can starve indefinitely under back-to-back pipeline writes. This is accepted behaviour: dependants stall on `busy_mask`.

## Timing
- **Reset** (on any edge with `rst` = 1):
  - `gpr_we` = 0, `gpr_addr` = 0, `gpr_data` = 0, `busy_mask` = 0.
  - FIFO is emptied and count = 0.
  - `ll_ready` = 0 while `rst` is high, and 1 in the first cycle after.
- **Reset mid-operation:** buffered results are discarded and all busy bits are cleared. An offered result in that cycle is not accepted.
- **Pipeline latency:** `pipe_we` sampled at edge N appears on `gpr_we` / `gpr_addr` / `gpr_data` after edge N, valid for cycle N+1 only.
- **Long-latency latency:** a result accepted at edge N becomes the FIFO head in cycle N+1. It drives `gpr_*` in cycle N+2 at the earliest, when no pipeline write occurs in N+1.
- **Busy-bit timing:**
  - A busy bit set by issue at edge N is visible in cycle N+1.
  - A busy bit is cleared on the same edge that registers the corresponding `gpr_we`. `busy_mask` drops in the same cycle the write is presented to the register file.
- **Write pulses:** `gpr_we` is a single-cycle pulse per write. No write is ever duplicated or dropped, other than r0 writes.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `ll_valid` = 1.
  - During reset, all outputs = 0 and `ll_ready` = 0, with no acceptance.
  - In the cycle after reset, `ll_ready` = 1.
- **Pipeline path:** `pipe_we`=1, addr 5, data 0xDEADBEEF at edge N.
  - Required: `gpr_we`=1, `gpr_addr`=5, `gpr_data`=0xDEADBEEF in cycle N+1 only.
  - Required: `busy_mask` unchanged.
- **Issue/drain:** issue addr 8, then offer result 0x12345678.
  - Required: `busy_mask`[8]=1 from the cycle after issue.
  - Required: a write to r8 two cycles after acceptance.
  - Required: `busy_mask`[8]=0 in the cycle the write is presented.
- **Contention:** `pipe_we`=1 every cycle for 4 cycles while DEPTH=2 results to r3 and r4 are offered.
  - Required: `ll_ready`=0 after two acceptances.
  - Required: pipeline writes occur back-to-back.
  - Required: r3 then r4 are written in the two cycles after `pipe_we` drops.
  - Required: busy bits clear in order.
- **r0 handling:**
  - Pipeline write to r0 with head pending for r7 → r7 is written the next cycle.
  - LL result to r0 → popped, `gpr_we` stays 0.
- **Same-edge set and clear:** the head for r9 is popped on the same edge `issue_valid`=1, `issue_addr`=9 → `busy_mask`[9] remains 1.
